// File: rtl/pipeexe_md.sv
// Execute stage: operand select, ALU and jal return address, plus an iterative
// multiply/divide unit with HI/LO registers and a stall request to the hazard unit.
module pipeexe_md #(
  parameter int W      = 32,
  parameter int SA_LSB = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   ealuc,
  input  logic         ealuimm,
  input  logic         eshift,
  input  logic         ejal,
  input  logic [W-1:0] ea,
  input  logic [W-1:0] eb,
  input  logic [W-1:0] eimm,
  input  logic [W-1:0] epc4,
  input  logic [4:0]   ern0,
  input  logic [3:0]   emdop,
  output logic [W-1:0] ealu,
  output logic [4:0]   ern,
  output logic         estall,
  output logic         ebusy
);
  localparam int             CW       = $clog2(W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]   PC_STEP  = W'(4);

  localparam logic [3:0] MD_MULT = 4'd1, MD_MULTU = 4'd2, MD_DIV  = 4'd3, MD_DIVU = 4'd4,
                         MD_MFHI = 4'd5, MD_MFLO  = 4'd6, MD_MTHI = 4'd7, MD_MTLO = 4'd8;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state, state_next;
  logic [CW-1:0] cnt;
  logic [W-1:0]  hi, lo;
  logic [W-1:0]  acc_hi, acc_lo, mcand;
  logic          is_div, neg_q, neg_r, dzero;

  // ---------------- ALU datapath ----------------
  logic [W-1:0] alua, alub, alu_r;

  assign alua = eshift  ? {{(W-5){1'b0}}, eimm[SA_LSB+4:SA_LSB]} : ea;
  assign alub = ealuimm ? eimm : eb;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_r = '0;
    casez (ealuc)
      4'b?000: alu_r = alua + alub;
      4'b?100: alu_r = alua - alub;
      4'b?001: alu_r = alua & alub;
      4'b?101: alu_r = alua | alub;
      4'b?010: alu_r = alua ^ alub;
      4'b?110: alu_r = alub << (W / 2);
      4'b0011: alu_r = alub << alua[4:0];
      4'b0111: alu_r = alub >> alua[4:0];
      4'b1111: alu_r = $signed(alub) >>> alua[4:0];
      default: alu_r = '0;
    endcase
  end

  // ---------------- Op decode and pipeline-facing outputs ----------------
  logic md_arith, md_any, md_nowrite, signed_op, start_div;

  assign md_arith   = (emdop >= MD_MULT) && (emdop <= MD_DIVU);
  assign md_any     = (emdop >= MD_MULT) && (emdop <= MD_MTLO);
  assign md_nowrite = md_arith || (emdop == MD_MTHI) || (emdop == MD_MTLO);
  assign signed_op  = (emdop == MD_MULT) || (emdop == MD_DIV);
  assign start_div  = (emdop == MD_DIV) || (emdop == MD_DIVU);

  assign ebusy  = (state == RUN);
  assign estall = ebusy & md_any;
  assign ern    = (md_nowrite || estall) ? 5'd0 : ern0;

  always_comb begin
    if (ejal)                  ealu = epc4 + PC_STEP;
    else if (emdop == MD_MFHI) ealu = hi;
    else if (emdop == MD_MFLO) ealu = lo;
    else                       ealu = alu_r;
  end

  // ---------------- Operand magnitudes latched at start ----------------
  logic         a_neg, b_neg;
  logic [W-1:0] mag_a, mag_b;

  assign a_neg = signed_op & ea[W-1];
  assign b_neg = signed_op & eb[W-1];
  assign mag_a = a_neg ? -ea : ea;
  assign mag_b = b_neg ? -eb : eb;

  // ---------------- One iteration: shift-add or restoring-divide step ----------------
  logic [W:0]     add_sum, div_shift, div_diff;
  logic [W-1:0]   step_hi, step_lo, q_fix, r_fix;
  logic [2*W-1:0] prod_fix;

  always_comb begin
    add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (is_div) begin
      step_hi = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
      step_lo = {acc_lo[W-2:0], ~div_diff[W]};
    end else begin
      step_hi = add_sum[W:1];
      step_lo = {add_sum[0], acc_lo[W-1:1]};
    end
    // Sign fix applied to the last step's result; a zero divisor forces an all-ones quotient.
    prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    q_fix    = dzero ? '1 : (neg_q ? -step_lo : step_lo);
    r_fix    = neg_r ? -step_hi : step_hi;
  end

  // ---------------- MD control FSM ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (md_arith) state_next = RUN;
      RUN:     if (cnt == CNT_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: HI/LO and the working registers are reset too, so an abandoned
  // operation leaves no stale product visible to a later mfhi/mflo.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dzero  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (state == IDLE) begin
        cnt <= '0;
        if (md_arith) begin
          is_div <= start_div;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          dzero  <= start_div && (eb == '0);
          acc_hi <= '0;
          acc_lo <= start_div ? mag_a : mag_b;
          mcand  <= start_div ? mag_b : mag_a;
        end else if (emdop == MD_MTHI) begin
          hi <= ea;
        end else if (emdop == MD_MTLO) begin
          lo <= ea;
        end
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (is_div) begin
          hi <= r_fix;
          lo <= q_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end else begin
        cnt    <= cnt + 1'b1;
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end
    end
  end

endmodule

// File: tb/tb_pipeexe_md.sv
// Directed bench for pipeexe_md: ALU/jal paths, MD results and stalls, reset
// during an operation, and a W = 16 multiply.
module tb_pipeexe_md;
  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4,
                         MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [3:0]  ealuc, emdop;
  logic        ealuimm, eshift, ejal;
  logic [31:0] ea, eb, eimm, epc4, ealu;
  logic [4:0]  ern0, ern;
  logic        estall, ebusy;

  logic [15:0] a16, b16, zero16, ealu16;
  logic [3:0]  op16, zero4;
  logic [4:0]  zero5, ern16;
  logic        zero1, estall16, ebusy16;

  int n_assert = 0;
  int n_fail   = 0;
  int cycles;

  pipeexe_md #(.W(32), .SA_LSB(6)) u32 (
    .clock(clock), .reset(reset), .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift),
    .ejal(ejal), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0), .emdop(emdop),
    .ealu(ealu), .ern(ern), .estall(estall), .ebusy(ebusy)
  );

  pipeexe_md #(.W(16), .SA_LSB(6)) u16 (
    .clock(clock), .reset(reset), .ealuc(zero4), .ealuimm(zero1), .eshift(zero1),
    .ejal(zero1), .ea(a16), .eb(b16), .eimm(zero16), .epc4(zero16), .ern0(zero5),
    .emdop(op16), .ealu(ealu16), .ern(ern16), .estall(estall16), .ebusy(ebusy16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts edges until estall drops, bounded so a stuck unit still reaches the summary.
  task automatic wait_free(output int n);
    n = 0;
    while (estall === 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  // Issue an MD op, follow it immediately with mfhi then mflo.
  // The dependent mfhi waits in EX for 32 edges before ebusy falls.
  task automatic md32(input string tag, input logic [3:0] op, input logic [31:0] a, b,
                      input logic [31:0] hi_exp, lo_exp);
    int n;
    emdop = op; ea = a; eb = b; ern0 = 5'd7; #1;
    check({tag, " issue ern"}, ern, 0);
    check({tag, " issue stall"}, estall, 0);
    @(posedge clock); #1;
    emdop = MFHI; ern0 = 5'd9; #1;
    check({tag, " busy"}, ebusy, 1);
    wait_free(n);
    check({tag, " stall cycles"}, n, 32);
    check({tag, " hi"}, ealu, hi_exp);
    check({tag, " mfhi ern"}, ern, 9);
    @(posedge clock); #1;
    emdop = MFLO; #1;
    check({tag, " lo"}, ealu, lo_exp);
    @(posedge clock); #1;
    emdop = NONE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ealuc = 4'd0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0;
    ea = '0; eb = '0; eimm = '0; epc4 = '0; ern0 = '0; emdop = NONE;
    a16 = '0; b16 = '0; zero16 = '0; op16 = NONE; zero4 = '0; zero5 = '0; zero1 = 1'b0;
    #2;
    check("reset ebusy", ebusy, 0);
    check("reset estall", estall, 0);
    check("reset ern", ern, 0);
    check("reset ealu add(0,0)", ealu, 0);
    check("reset ebusy16", ebusy16, 0);
    emdop = MFHI; #1;
    check("reset hi", ealu, 0);
    emdop = MFLO; #1;
    check("reset lo", ealu, 0);
    emdop = NONE;
    @(posedge clock); #1;
    reset = 1'b0;

    // ALU and jal paths
    eshift = 1'b1; eimm = 32'd4 << 6; eb = 32'h1; ealuc = 4'b0011; ern0 = 5'd5; #1;
    check("sll shamt", ealu, 32'h10);
    check("sll ern", ern, 5);
    eb = 32'h8000_0000; ealuc = 4'b1111; #1;
    check("sra shamt", ealu, 32'hF800_0000);
    eshift = 1'b0; ealuimm = 1'b1; ea = 32'd10; eimm = 32'd3; ealuc = 4'b0100; #1;
    check("sub imm", ealu, 7);
    eimm = 32'h1234; ealuc = 4'b0110; #1;
    check("lui", ealu, 32'h1234_0000);
    ealuimm = 1'b0; ejal = 1'b1; epc4 = 32'h100; ern0 = 5'd31; #1;
    check("jal ealu", ealu, 32'h104);
    check("jal ern", ern, 31);
    ejal = 1'b0; ealuc = 4'd0;
    @(posedge clock); #1;

    md32("mult -3*7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    md32("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md32("divu", DIVU, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC);
    md32("div 5/0", DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    md32("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Non-MD add during RUN proceeds; mthi during RUN stalls and lands after the mult.
    emdop = MULT; ea = 32'd6; eb = 32'd7; @(posedge clock); #1;
    emdop = NONE; ea = 32'd100; eb = 32'd23; ern0 = 5'd4; #1;
    check("add in run busy", ebusy, 1);
    check("add in run stall", estall, 0);
    check("add in run ealu", ealu, 123);
    check("add in run ern", ern, 4);
    @(posedge clock); #1;
    emdop = MTHI; ea = 32'hABCD_1234; ern0 = 5'd6; #1;
    check("mthi in run stall", estall, 1);
    check("mthi in run ern", ern, 0);
    wait_free(cycles);
    check("mthi stall cycles", cycles, 31);
    @(posedge clock); #1;
    emdop = MFHI; #1;
    check("mfhi after mthi", ealu, 32'hABCD_1234);
    @(posedge clock); #1;
    emdop = MFLO; #1;
    check("mflo after mult 6*7", ealu, 42);
    emdop = NONE;
    @(posedge clock); #1;

    // Reset at cnt = 10 of a mult
    emdop = MULT; ea = 32'h1234_5678; eb = 32'h100; @(posedge clock); #1;
    emdop = NONE;
    repeat (10) @(posedge clock);
    #1;
    check("pre-reset busy", ebusy, 1);
    reset = 1'b1; emdop = MFHI; #1;
    check("mid-run reset busy", ebusy, 0);
    check("mid-run reset stall", estall, 0);
    check("mid-run reset hi", ealu, 0);
    emdop = MFLO; #1;
    check("mid-run reset lo", ealu, 0);
    emdop = NONE;
    @(posedge clock); #1;
    reset = 1'b0;
    md32("multu after reset", MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

    // W = 16 multiply
    op16 = MULT; a16 = 16'hFFFD; b16 = 16'd7; @(posedge clock); #1;
    op16 = MFHI; #1;
    check("w16 busy", ebusy16, 1);
    cycles = 0;
    while (estall16 === 1'b1 && cycles < 200) begin
      @(posedge clock); #1;
      cycles++;
    end
    check("w16 stall cycles", cycles, 16);
    check("w16 hi", ealu16, 16'hFFFF);
    @(posedge clock); #1;
    op16 = MFLO; #1;
    check("w16 lo", ealu16, 16'hFFEB);
    op16 = NONE;
    @(posedge clock); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
